// File: rtl/avalon_burst_master.sv
// avalon_burst_master
//   Avalon-MM burst master. Accepts one command at a time (write or read of
//   cmd_len words starting at BASE_ADDR+cmd_addr) and runs it as single-word
//   Avalon transfers, one transfer per cycle that the slave is not stalling.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   waitrequest            slave stall
//   readdatavalid/readdata slave read return
//   read_n/write_n         active-low strobes, decoded from state
//   chipselect             tied high
//   address                word address (wraps modulo 2^ADDR_W)
//   byteenable             all ones
//   writedata              wr_data passed through during WRITE
//   cmd_valid/cmd_write/cmd_addr/cmd_len, cmd_ready  command handshake
//   wr_data/wr_ack         write source, pulse when a word is consumed
//   rd_data/rd_valid       registered read return
//   busy/done/error        status; done is a one-cycle pulse, error sticky
//
// Optional feature
//   AVALON_BURST_MASTER_TIMEOUT_EN : stall watchdog of TIMEOUT_CYC cycles
//   that sets error and forces DONE. Undefined: no watchdog, error tied 0.

module avalon_burst_master #(
  parameter int          DATA_W      = 16,
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          MAX_LEN     = 16,
  parameter int          TIMEOUT_CYC = 1024,
  localparam int         LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                waitrequest,
  input  logic                readdatavalid,
  input  logic [DATA_W-1:0]   readdata,
  output logic                read_n,
  output logic                write_n,
  output logic                chipselect,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic [DATA_W-1:0]   writedata,
  input  logic                cmd_valid,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_ack,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                done,
  output logic                error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    remain_q;
  logic [LEN_W-1:0]    outst_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;

  logic                issue_rd;
  logic                ret;
  logic                stall_hit;
  logic [LEN_W-1:0]    len_clamped;
  logic [ADDR_W-1:0]   base;

  assign base        = ADDR_W'(BASE_ADDR);
  assign len_clamped = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;

  assign issue_rd = (state_q == S_READ) && !waitrequest;
  // Returns are only meaningful while a read is in flight.
  assign ret      = readdatavalid && ((state_q == S_READ) || (state_q == S_DRAIN));

  assign read_n     = (state_q != S_READ);
  assign write_n    = (state_q != S_WRITE);
  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign chipselect = 1'b1;
  assign byteenable = '1;
  assign address    = addr_q;
  assign writedata  = wr_data;
  assign wr_ack     = (state_q == S_WRITE) && !waitrequest;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

`ifdef AVALON_BURST_MASTER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

  logic [STALL_W-1:0] stall_q;
  logic               error_q;
  logic               stalling;

  assign stalling = (((state_q == S_WRITE) || (state_q == S_READ)) && waitrequest) ||
                    ((state_q == S_DRAIN) && !readdatavalid);
  assign stall_hit = stalling && (stall_q == STALL_W'(TIMEOUT_CYC - 1));
  assign error     = error_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      error_q <= 1'b0;
    end else if ((state_q == S_IDLE) && cmd_valid) begin
      stall_q <= '0;
      error_q <= 1'b0;
    end else if (stall_hit) begin
      stall_q <= '0;
      error_q <= 1'b1;
    end else if (stalling) begin
      stall_q <= stall_q + STALL_W'(1);
    end else begin
      stall_q <= '0;
    end
  end
`else
  assign stall_hit = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= base;
      remain_q   <= '0;
      outst_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= ret;
      if (ret) rd_data_q <= readdata;

      // Issue and return in the same cycle cancel out.
      if (issue_rd && !ret)
        outst_q <= outst_q + LEN_W'(1);
      else if (!issue_rd && ret && (outst_q != '0))
        outst_q <= outst_q - LEN_W'(1);

      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q   <= base + cmd_addr;
            remain_q <= len_clamped;
            if (len_clamped == '0) state_q <= S_DONE;
            else if (cmd_write)    state_q <= S_WRITE;
            else                   state_q <= S_READ;
          end
        end
        S_WRITE: begin
          if (!waitrequest) begin
            addr_q   <= addr_q + ADDR_W'(1);
            remain_q <= remain_q - LEN_W'(1);
            if (remain_q == LEN_W'(1)) state_q <= S_DONE;
          end
        end
        S_READ: begin
          if (!waitrequest) begin
            addr_q   <= addr_q + ADDR_W'(1);
            remain_q <= remain_q - LEN_W'(1);
            if (remain_q == LEN_W'(1)) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The last return is registered on the same edge outst_q reaches 0,
          // so its rd_valid is already on the port when this condition holds.
          if (outst_q == '0) state_q <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      if (stall_hit) begin
        state_q  <= S_DONE;
        remain_q <= '0;
        outst_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_avalon_burst_master.sv
module tb_avalon_burst_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        waitrequest;
  logic        readdatavalid;
  logic [15:0] readdata;
  logic        read_n, write_n, chipselect;
  logic [31:0] address;
  logic [1:0]  byteenable;
  logic [15:0] writedata;
  logic        cmd_valid, cmd_write;
  logic [31:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic        cmd_ready;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic [15:0] rd_data;
  logic        rd_valid, busy, done, error;

  int n_cmp = 0;
  int n_bad = 0;

  // Read burst table, cycle index 0 = first cycle after accept.
  logic        rn_tab   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        rdv_tab  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [15:0] rin_tab  [8] = '{16'h0, 16'h0, 16'hA1, 16'hA2, 16'hA3, 16'hA4, 16'h0, 16'h0};
  logic        rv_tab   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] rd_tab   [8] = '{16'h0, 16'h0, 16'h0, 16'hA1, 16'hA2, 16'hA3, 16'hA4, 16'h0};
  logic        done_tab [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  avalon_burst_master #(
    .DATA_W     (16),
    .ADDR_W     (32),
    .BASE_ADDR  (32'h0),
    .MAX_LEN    (16),
    .TIMEOUT_CYC(1024)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .waitrequest  (waitrequest),
    .readdatavalid(readdatavalid),
    .readdata     (readdata),
    .read_n       (read_n),
    .write_n      (write_n),
    .chipselect   (chipselect),
    .address      (address),
    .byteenable   (byteenable),
    .writedata    (writedata),
    .cmd_valid    (cmd_valid),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .cmd_ready    (cmd_ready),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [4:0] l);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cnt;
    reset_n = 1'b0; waitrequest = 1'b0; readdatavalid = 1'b0; readdata = '0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; wr_data = '0;
    settle();
    chk("rst_read_n", read_n, 1);
    chk("rst_write_n", write_n, 1);
    chk("rst_cs", chipselect, 1);
    chk("rst_be", byteenable, 2'b11);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_rvalid", rd_valid, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_wack", wr_ack, 0);
    chk("rst_addr", address, 0);
    step(); step();
    reset_n = 1'b1;
    step();

    // Write 3 words at 4, no stall
    wr_data = 16'hB000;
    issue_cmd(1'b1, 32'd4, 5'd3);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      wr_data = 16'hB000 + 16'(i);
      settle();
      chk("wr_wn", write_n, 0);
      chk("wr_rn", read_n, 1);
      chk("wr_addr", address, 32'(4 + i));
      chk("wr_ack", wr_ack, 1);
      chk("wr_wdata", writedata, 64'(16'hB000 + 16'(i)));
    end
    step(); settle();
    chk("wr_done", done, 1);
    chk("wr_done_wn", write_n, 1);
    chk("wr_done_busy", busy, 1);
    step(); settle();
    chk("wr_idle_ready", cmd_ready, 1);
    chk("wr_idle_done", done, 0);
    chk("wr_idle_busy", busy, 0);

    // Write 2 words with a 5-cycle stall on word 0
    wr_data = 16'h1234;
    issue_cmd(1'b1, 32'd10, 5'd2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      waitrequest = 1'b1;
      settle();
      chk("st_wn", write_n, 0);
      chk("st_addr", address, 10);
      chk("st_ack", wr_ack, 0);
      chk("st_wdata", writedata, 16'h1234);
    end
    step(); waitrequest = 1'b0; settle();
    chk("st_w0_addr", address, 10);
    chk("st_w0_ack", wr_ack, 1);
    step(); wr_data = 16'h5678; settle();
    chk("st_w1_addr", address, 11);
    chk("st_w1_ack", wr_ack, 1);
    chk("st_w1_wdata", writedata, 16'h5678);
    step(); settle();
    chk("st_done", done, 1);
    chk("st_done_ack", wr_ack, 0);
    step(); settle();
    chk("st_idle", cmd_ready, 1);

    // Read 4 words at 20, returns two cycles after each issue
    issue_cmd(1'b0, 32'd20, 5'd4);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      readdatavalid = rdv_tab[c];
      readdata      = rin_tab[c];
      settle();
      chk("rd_rn", read_n, rn_tab[c]);
      chk("rd_wn", write_n, 1);
      if (!rn_tab[c]) chk("rd_addr", address, 32'(20 + c));
      chk("rd_valid", rd_valid, rv_tab[c]);
      if (rv_tab[c]) chk("rd_data", rd_data, rd_tab[c]);
      chk("rd_done", done, done_tab[c]);
    end
    readdatavalid = 1'b0;
    step(); settle();
    chk("rd_idle", cmd_ready, 1);

    // Stray return in IDLE is ignored
    readdatavalid = 1'b1; readdata = 16'hBEEF;
    step(); readdatavalid = 1'b0; settle();
    chk("ign_idle_rv", rd_valid, 0);
    chk("ign_idle_rd", rd_data, 16'hA4);

    // Zero-length command
    issue_cmd(1'b0, 32'd50, 5'd0);
    settle();
    chk("z_done", done, 1);
    chk("z_rn", read_n, 1);
    chk("z_wn", write_n, 1);
    chk("z_busy", busy, 1);
    step(); settle();
    chk("z_idle", cmd_ready, 1);

    // Address wrap; stray return during WRITE ignored
    wr_data = 16'h0F0F;
    issue_cmd(1'b1, 32'hFFFF_FFFF, 5'd2);
    readdatavalid = 1'b1; readdata = 16'hCAFE;
    settle();
    chk("wrap_a0", address, 32'hFFFF_FFFF);
    step(); readdatavalid = 1'b0; settle();
    chk("wrap_a1", address, 0);
    chk("wrap_ack", wr_ack, 1);
    chk("ign_wr_rv", rd_valid, 0);
    step(); settle();
    chk("wrap_done", done, 1);
    chk("wrap_err", error, 0);
    step(); settle();

    // Length above MAX_LEN clamps to 16 words
    issue_cmd(1'b1, 32'd100, 5'd31);
    settle();
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) break;
      if (!write_n) cnt++;
      step(); settle();
    end
    chk("clamp_cnt", cnt, 16);
    chk("clamp_done", done, 1);
    chk("clamp_addr", address, 116);
    step(); settle();

    // Reset during a read with 2 outstanding
    issue_cmd(1'b0, 32'd60, 5'd4);
    settle();
    chk("ra_addr0", address, 60);
    step(); settle();
    chk("ra_addr1", address, 61);
    step(); reset_n = 1'b0; settle();
    chk("ra_rn", read_n, 1);
    chk("ra_busy", busy, 0);
    chk("ra_ready", cmd_ready, 1);
    chk("ra_addr", address, 0);
    chk("ra_rv", rd_valid, 0);
    chk("ra_rd", rd_data, 0);
    step(); reset_n = 1'b1; readdatavalid = 1'b1; readdata = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      chk("ra_late_rv", rd_valid, 0);
    end
    readdatavalid = 1'b0;
    step();

    // No watchdog in the default build: stalls forever
    issue_cmd(1'b1, 32'd0, 5'd1);
    waitrequest = 1'b1;
    repeat (100) step();
    settle();
    chk("nto_busy", busy, 1);
    chk("nto_wn", write_n, 0);
    chk("nto_err", error, 0);
    waitrequest = 1'b0;
    step(); settle();
    chk("nto_done", done, 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/avalon_burst_master.md
AVALON_BURST_MASTER -- requirements
Module: avalon_burst_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16, Avalon data width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 32, Avalon word-address width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, word base added to every command offset.
REQ-004 SHALL have parameter MAX_LEN, default 16, maximum words per command; LEN_W = clog2(MAX_LEN+1).
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024, stall limit used only under REQ-030.
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-008 waitrequest  in  1  Avalon slave stall.
REQ-009 readdatavalid  in  1  Avalon read-data strobe; readdata  in  DATA_W  Avalon read data.
REQ-010 read_n, write_n  out  1 each  active-low Avalon strobes; chipselect  out  1  constant 1.
REQ-011 address  out  ADDR_W  word address; byteenable  out  DATA_W/8  all ones; writedata  out  DATA_W.
REQ-012 cmd_valid  in  1, cmd_write  in  1, cmd_addr  in  ADDR_W, cmd_len  in  LEN_W  command request.
REQ-013 cmd_ready  out  1  high exactly when state is IDLE.
REQ-014 wr_data  in  DATA_W  write source; wr_ack  out  1  one-cycle pulse when the current wr_data word is consumed.
REQ-015 rd_data  out  DATA_W, rd_valid  out  1  one-cycle strobe per returned word.
REQ-016 busy  out  1, done  out  1  pulse, error  out  1  sticky flag.

Function
REQ-017 States SHALL be IDLE, WRITE, READ, DRAIN, DONE.
REQ-018 In IDLE, cmd_valid&&cmd_ready SHALL latch address=BASE_ADDR+cmd_addr and remaining=cmd_len, clear error, and go to WRITE if cmd_write else READ.
REQ-019 A command with cmd_len==0 SHALL go straight to DONE with no bus cycle; cmd_len>MAX_LEN SHALL be clamped to MAX_LEN.
REQ-020 In WRITE, write_n=0 and writedata=wr_data; on a cycle with ~waitrequest, wr_ack=1, address+=1, remaining-=1; go to DONE when remaining reaches 0.
REQ-021 In READ, read_n=0; each ~waitrequest cycle issues one word: address+=1, remaining-=1, outstanding+=1; after the last issue go to DRAIN.
REQ-022 Each readdatavalid SHALL register readdata to rd_data with rd_valid=1 one cycle later and decrement outstanding; issue and return in the same cycle leave outstanding unchanged.
REQ-023 DRAIN SHALL deassert read_n and go to DONE when outstanding is 0 and no rd_valid is pending.
REQ-024 DONE SHALL last one cycle with done=1 and then go to IDLE; busy=1 in every state except IDLE.
REQ-025 Address SHALL wrap modulo 2^ADDR_W without error.
REQ-026 read_n, write_n and cmd_ready SHALL be decoded combinationally from state only; never both strobes low.
REQ-027 readdatavalid in IDLE or WRITE SHALL be ignored without a strobe or counter change.

Reset
REQ-028 On reset_n low: state=IDLE, address=BASE_ADDR, remaining=0, outstanding=0, read_n=1, write_n=1, chipselect=1, rd_data=0, rd_valid=0, wr_ack=0, done=0, busy=0, error=0.
REQ-029 A reset mid-transfer SHALL abort immediately; no late readdatavalid after release produces rd_valid.

Configuration
REQ-030 With macro AVALON_BURST_MASTER_TIMEOUT_EN defined, a stall counter SHALL count consecutive cycles in WRITE/READ with waitrequest=1, or in DRAIN with no readdatavalid; at TIMEOUT_CYC the block SHALL set error=1, go to DONE, and zero the counters.
REQ-031 Without the macro, the block SHALL have no stall counter, waits indefinitely, and ties error=0.

Verification
REQ-032 Write cmd_addr=4, len=3, no waitrequest -> addresses 4,5,6 with write_n low 3 cycles, 3 wr_ack pulses, done at cycle 4.
REQ-033 Read len=4, readdatavalid 2 cycles after each issue, data A1..A4 -> rd_data A1..A4 in order, done after the 4th rd_valid.
REQ-034 Write len=2 with waitrequest high for 5 cycles on word 0 -> address held, single wr_ack per word, writedata stable while stalled.
REQ-035 cmd_len=0 -> no strobe, done 1 cycle after accept; address 32'hFFFFFFFF with len=2 -> second word at 0.
REQ-036 reset_n low during READ with 2 outstanding -> outputs at reset values in the same cycle and no rd_valid afterwards.
REQ-037 Macro defined, TIMEOUT_CYC=8, waitrequest held high -> error=1 and done 8 cycles after strobe assert; macro undefined -> still busy after 100 cycles.
